// File: rtl/fifo_pkg.sv
// Shared FIFO-side types and limits for the write arbiter and its read-side counterparts.
package fifo_pkg;

    localparam int DATA_WIDTH        = 16;
    localparam int ARB_N_REQ_MAX     = 16;
    localparam int ARB_MAX_BURST_MAX = 15;

    typedef logic [DATA_WIDTH-1:0] fifo_data_t;

    // Skid register occupancy: EMPTY means out_vld=0, HELD means out_vld=1.
    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } skid_state_t;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side request bus plus FIFO write channel of the write arbiter.
interface fifo_wr_arbiter_if #(
    parameter int N_REQ = 4
);
    import fifo_pkg::*;

    logic [N_REQ-1:0]            req;
    logic [N_REQ*DATA_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]            gnt;
    logic                        full;
    logic                        wr_en;
    fifo_data_t                  wr_data;
    logic [$clog2(N_REQ)-1:0]    owner_id;
    logic                        out_vld;

    // master is the arbiter itself; slave is the producers + FIFO environment.
    modport master (
        input  req, req_data, full,
        output gnt, wr_en, wr_data, owner_id, out_vld
    );

    modport slave (
        output req, req_data, full,
        input  gnt, wr_en, wr_data, owner_id, out_vld
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_priority_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping modulo N.
module rr_priority_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt
);

    localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] rot_req;
    logic [N-1:0] rot_gnt;

    // Rotate so ptr lands on bit 0, isolate the lowest set bit, then rotate back.
    always_comb begin
        rot_req = N'({req, req} >> ptr);
        rot_gnt = rot_req & (~rot_req + ONE_N);
        gnt     = N'(({rot_gnt, rot_gnt} << ptr) >> N);
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter with a one-entry skid register in front of a FIFO write port.
// Optional burst mode (owner keeps priority for up to MAX_BURST grants) via `define FIFO_ARB_BURST_EN.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 4
) (
    input logic              clk,
    input logic              rst_n,
    fifo_wr_arbiter_if.master bus
);

    localparam int             IW       = $clog2(N_REQ);
    localparam logic [IW-1:0]  LAST_IDX = IW'(N_REQ - 1);
    localparam logic [IW-1:0]  ONE_IDX  = IW'(1);

    if (N_REQ < 2 || N_REQ > ARB_N_REQ_MAX) begin : g_bad_n_req
        $error("fifo_wr_arbiter: N_REQ out of range");
    end
    if (MAX_BURST < 1 || MAX_BURST > ARB_MAX_BURST_MAX) begin : g_bad_max_burst
        $error("fifo_wr_arbiter: MAX_BURST out of range");
    end

    skid_state_t      state;
    fifo_data_t       out_data;
    logic [IW-1:0]    owner_id_q;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    pick_ptr;
    logic [IW-1:0]    gnt_idx;
    logic [IW-1:0]    next_ptr;
    logic [N_REQ-1:0] pick_gnt;
    logic [N_REQ-1:0] gnt_int;
    fifo_data_t       gnt_data;
    logic             out_vld_int;
    logic             wr_en_int;
    logic             accept;

`ifdef FIFO_ARB_BURST_EN
    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);
    logic [3:0] burst_cnt;
    logic       owner_keeps;
`endif

    assign out_vld_int = (state == HELD);
    // rst_n gates the write strobe so a held entry can never leak out during reset.
    assign wr_en_int   = rst_n & out_vld_int & ~bus.full;
    assign accept      = rst_n & (~out_vld_int | wr_en_int);

`ifdef FIFO_ARB_BURST_EN
    assign owner_keeps = (burst_cnt != 4'd0) && (burst_cnt < BURST_LIM) && bus.req[owner_id_q];
    assign pick_ptr    = owner_keeps ? owner_id_q : rr_ptr;
`else
    assign pick_ptr    = rr_ptr;
`endif

    rr_priority_pick #(
        .N   (N_REQ)
    ) u_pick (
        .req (bus.req),
        .ptr (pick_ptr),
        .gnt (pick_gnt)
    );

    always_comb begin
        gnt_int  = accept ? pick_gnt : '0;
        gnt_idx  = '0;
        gnt_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_int[i]) begin
                gnt_idx  = IW'(i);
                gnt_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        next_ptr = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + ONE_IDX;
    end

    // Skid FSM: a grant always (re)loads, a write without a grant empties.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= EMPTY;
            out_data   <= '0;
            owner_id_q <= '0;
            rr_ptr     <= '0;
`ifdef FIFO_ARB_BURST_EN
            burst_cnt  <= 4'd0;
`endif
        end else if (|gnt_int) begin
            state      <= HELD;
            out_data   <= gnt_data;
            owner_id_q <= gnt_idx;
`ifdef FIFO_ARB_BURST_EN
            if ((burst_cnt != 4'd0) && (gnt_idx == owner_id_q)) begin
                if (burst_cnt < BURST_LIM) begin
                    burst_cnt <= burst_cnt + 4'd1;
                end
            end else begin
                burst_cnt <= 4'd1;
                rr_ptr    <= next_ptr;
            end
`else
            rr_ptr     <= next_ptr;
`endif
        end else if (wr_en_int) begin
            state <= EMPTY;
        end
    end

    assign bus.gnt      = gnt_int;
    assign bus.wr_en    = wr_en_int;
    assign bus.wr_data  = out_data;
    assign bus.owner_id = owner_id_q;
    assign bus.out_vld  = out_vld_int;

`ifndef SYNTHESIS
    a_gnt_onehot0 : assert property (@(posedge clk) $onehot0(bus.gnt));
    a_gnt_has_req : assert property (@(posedge clk) (bus.gnt & ~bus.req) == '0);
    a_no_wr_full  : assert property (@(posedge clk) !(bus.wr_en && bus.full));
    a_data_stable : assert property (@(posedge clk) disable iff (!rst_n)
                        (bus.out_vld && bus.full && $past(bus.out_vld && bus.full)) |-> $stable(bus.wr_data));
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus random traffic vs a behavioural model.
module tb_fifo_wr_arbiter;

    localparam int N    = 4;
    localparam int MAXB = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.N_REQ(N)) bus();

    fifo_wr_arbiter #(
        .N_REQ     (N),
        .MAX_BURST (MAXB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int total = 0;
    int bad   = 0;

    logic [15:0] src_data [N];

    // Model: the held entry, the last granted source and how many grants in a row it has had.
    bit          m_vld;
    logic [15:0] m_data;
    int          m_owner;
    bit          m_have_last;
    int          m_streak;

    logic [N-1:0] exp_gnt;
    bit           exp_wr_en;
    int           exp_k;

    task automatic drive_data();
        for (int i = 0; i < N; i++) bus.req_data[i*16 +: 16] = src_data[i];
    endtask

    function automatic int model_pick(logic [N-1:0] r);
        int start;
        if (r == '0) return -1;
`ifdef FIFO_ARB_BURST_EN
        if (m_have_last && m_streak < MAXB && r[m_owner]) return m_owner;
`endif
        start = m_have_last ? (m_owner + 1) % N : 0;
        for (int j = 0; j < N; j++) begin
            if (r[(start + j) % N]) return (start + j) % N;
        end
        return -1;
    endfunction

    task automatic settle();
        @(negedge clk);
        exp_wr_en = rst_n && m_vld && !bus.full;
        exp_k     = (rst_n && (!m_vld || exp_wr_en)) ? model_pick(bus.req) : -1;
        exp_gnt   = '0;
        if (exp_k >= 0) exp_gnt[exp_k] = 1'b1;
    endtask

    task automatic tick();
        if (!rst_n) begin
            m_vld = 0; m_data = '0; m_owner = 0; m_have_last = 0; m_streak = 0;
        end else if (exp_k >= 0) begin
            m_streak    = (m_have_last && exp_k == m_owner) ? m_streak + 1 : 1;
            m_vld       = 1;
            m_data      = src_data[exp_k];
            m_owner     = exp_k;
            m_have_last = 1;
        end else if (exp_wr_en) begin
            m_vld = 0;
        end
        @(posedge clk);
        #1;
        if (rst_n && exp_k >= 0) begin
            src_data[exp_k] = 16'($urandom);
            drive_data();
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        bus.req  = '0;
        bus.full = 1'b0;
        settle(); tick();
        settle(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        bus.req  = 4'b1111;
        bus.full = 1'b0;
        settle(); tick();
        settle();
        total++; if (bus.gnt !== 4'b0000) begin bad++; $display("[TB] FAIL reset_gnt: got %b expected 0000", bus.gnt); end
        total++; if (bus.wr_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_wr_en: got %b expected 0", bus.wr_en); end
        total++; if (bus.out_vld !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_vld: got %b expected 0", bus.out_vld); end
        tick();
        rst_n = 1'b1;
        settle();
        total++; if (bus.gnt !== 4'b0001) begin bad++; $display("[TB] FAIL reset_release_gnt: got %b expected 0001", bus.gnt); end
        tick();
        settle();
        total++; if (bus.out_vld !== 1'b1 || bus.owner_id !== 2'd0) begin
            bad++; $display("[TB] FAIL reset_first_entry: got vld=%b owner=%0d expected vld=1 owner=0", bus.out_vld, bus.owner_id);
        end
        tick();
    endtask

    task automatic test_rr_fairness();
        do_reset();
        bus.req  = 4'b1111;
        bus.full = 1'b0;
        for (int c = 0; c < 9; c++) begin
            settle();
            total++; if (bus.gnt !== 4'(1 << (c % 4))) begin
                bad++; $display("[TB] FAIL rr_gnt[%0d]: got %b expected %b", c, bus.gnt, 4'(1 << (c % 4)));
            end
            if (c >= 1) begin
                total++; if (bus.wr_en !== 1'b1 || bus.owner_id !== 2'((c - 1) % 4) || bus.wr_data !== m_data) begin
                    bad++; $display("[TB] FAIL rr_write[%0d]: got en=%b src=%0d data=%h expected en=1 src=%0d data=%h",
                                    c, bus.wr_en, bus.owner_id, bus.wr_data, (c - 1) % 4, m_data);
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        src_data[2] = 16'hA5A5;
        drive_data();
        bus.req  = 4'b0100;
        bus.full = 1'b0;
        settle();
        total++; if (bus.gnt !== 4'b0100) begin bad++; $display("[TB] FAIL bp_load_gnt: got %b expected 0100", bus.gnt); end
        tick();
        bus.req  = 4'b1011;
        bus.full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            settle();
            total++; if (bus.wr_en !== 1'b0 || bus.gnt !== 4'b0000 || bus.wr_data !== 16'hA5A5 || bus.owner_id !== 2'd2) begin
                bad++; $display("[TB] FAIL bp_stall[%0d]: got en=%b gnt=%b data=%h owner=%0d expected en=0 gnt=0000 data=a5a5 owner=2",
                                c, bus.wr_en, bus.gnt, bus.wr_data, bus.owner_id);
            end
            tick();
        end
        bus.full = 1'b0;
        settle();
        total++; if (bus.wr_en !== 1'b1 || bus.wr_data !== 16'hA5A5 || bus.gnt !== 4'b1000) begin
            bad++; $display("[TB] FAIL bp_release: got en=%b data=%h gnt=%b expected en=1 data=a5a5 gnt=1000",
                            bus.wr_en, bus.wr_data, bus.gnt);
        end
        tick();
        settle();
        total++; if (bus.owner_id !== 2'd3 || bus.wr_data !== m_data) begin
            bad++; $display("[TB] FAIL bp_next: got owner=%0d data=%h expected owner=3 data=%h", bus.owner_id, bus.wr_data, m_data);
        end
        tick();
    endtask

    task automatic test_wrap_sparse();
        logic [3:0] seq [3];
        seq = '{4'b1000, 4'b0001, 4'b1000};
        do_reset();
        bus.req  = 4'b0001;
        bus.full = 1'b0;
        settle();
        total++; if (bus.gnt !== 4'b0001) begin bad++; $display("[TB] FAIL wrap_setup: got %b expected 0001", bus.gnt); end
        tick();
        bus.req = 4'b1001;
        for (int c = 0; c < 3; c++) begin
            settle();
            total++; if (bus.gnt !== seq[c]) begin
                bad++; $display("[TB] FAIL wrap_gnt[%0d]: got %b expected %b", c, bus.gnt, seq[c]);
            end
            tick();
        end
    endtask

`ifdef FIFO_ARB_BURST_EN
    task automatic test_burst();
        int seq [9];
        seq = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
        do_reset();
        bus.req  = 4'b0011;
        bus.full = 1'b0;
        for (int c = 0; c < 9; c++) begin
            settle();
            total++; if (bus.gnt !== 4'(1 << seq[c])) begin
                bad++; $display("[TB] FAIL burst_gnt[%0d]: got %b expected %b", c, bus.gnt, 4'(1 << seq[c]));
            end
            tick();
        end
        do_reset();
        bus.req = 4'b0011;
        settle(); tick();
        settle(); tick();
        bus.req = 4'b0010;
        settle();
        total++; if (bus.gnt !== 4'b0010) begin bad++; $display("[TB] FAIL burst_handover: got %b expected 0010", bus.gnt); end
        tick();
    endtask
`endif

    task automatic test_midop_reset();
        do_reset();
        bus.req  = 4'b0001;
        bus.full = 1'b0;
        settle(); tick();
        bus.req  = 4'b0000;
        bus.full = 1'b1;
        settle();
        total++; if (bus.out_vld !== 1'b1 || bus.wr_en !== 1'b0) begin
            bad++; $display("[TB] FAIL midrst_held: got vld=%b en=%b expected vld=1 en=0", bus.out_vld, bus.wr_en);
        end
        tick();
        rst_n    = 1'b0;
        bus.full = 1'b0;
        settle();
        total++; if (bus.wr_en !== 1'b0 || bus.gnt !== 4'b0000) begin
            bad++; $display("[TB] FAIL midrst_during: got en=%b gnt=%b expected en=0 gnt=0000", bus.wr_en, bus.gnt);
        end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            total++; if (bus.out_vld !== 1'b0 || bus.wr_en !== 1'b0) begin
                bad++; $display("[TB] FAIL midrst_after[%0d]: got vld=%b en=%b expected vld=0 en=0", c, bus.out_vld, bus.wr_en);
            end
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            bus.req  = 4'($urandom);
            bus.full = ($urandom_range(0, 3) == 0);
            rst_n    = ($urandom_range(0, 60) != 0);
            settle();
            total++; if (bus.gnt !== exp_gnt) begin
                bad++; $display("[TB] FAIL rand_gnt[%0d]: got %b expected %b", c, bus.gnt, exp_gnt);
            end
            total++; if (bus.wr_en !== exp_wr_en || bus.out_vld !== m_vld) begin
                bad++; $display("[TB] FAIL rand_ctrl[%0d]: got en=%b vld=%b expected en=%b vld=%b", c, bus.wr_en, bus.out_vld, exp_wr_en, m_vld);
            end
            total++; if (bus.wr_data !== m_data || bus.owner_id !== 2'(m_owner)) begin
                bad++; $display("[TB] FAIL rand_entry[%0d]: got data=%h owner=%0d expected data=%h owner=%0d",
                                c, bus.wr_data, bus.owner_id, m_data, m_owner);
            end
            tick();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        bus.req  = '0;
        bus.full = 1'b0;
        for (int i = 0; i < N; i++) src_data[i] = 16'($urandom);
        drive_data();
        m_vld = 0; m_data = '0; m_owner = 0; m_have_last = 0; m_streak = 0;
        test_reset();
`ifdef FIFO_ARB_BURST_EN
        test_burst();
`else
        test_rr_fairness();
        test_wrap_sparse();
`endif
        test_backpressure();
        test_midop_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
